// File: rtl/ball_launcher.sv
// Ball launcher: releases blue/red balls into the piece network, reacts to the
// lever/interceptor feedback, and keeps magazine and tray counts per colour.
module ball_launcher #(
    parameter int BLUE_COUNT  = 8,
    parameter int RED_COUNT   = 8,
    parameter int CNT_W       = 4,
    parameter int START_COLOR = 0,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reload,
    input  logic             blue_sink,
    input  logic             red_sink,
    input  logic             int_full,
    output logic             blue_ball,
    output logic             red_ball,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       halt_reason,
    output logic [CNT_W-1:0] blue_left,
    output logic [CNT_W-1:0] red_left,
    output logic [CNT_W-1:0] blue_tray,
    output logic [CNT_W-1:0] red_tray
);

    typedef enum logic [1:0] {S_IDLE, S_RELEASE, S_FLIGHT, S_HALT} state_t;

    localparam logic [1:0] HR_NONE    = 2'b00;
    localparam logic [1:0] HR_INT     = 2'b01;
    localparam logic [1:0] HR_EMPTY   = 2'b10;
    localparam logic [1:0] HR_TIMEOUT = 2'b11;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    state_t            state, state_nx;
    logic [TO_W-1:0]   to_cnt, to_nx, to_inc;
    logic              flight_color, flight_nx;
    logic              req_color, req_nx;
    logic              req_go, req_c, req_ok;
    logic              blue_ball_nx, red_ball_nx;
    logic [1:0]        halt_reason_nx;
    logic [CNT_W-1:0]  blue_left_nx, red_left_nx, blue_tray_nx, red_tray_nx;

    // Next-state and next-output computation
    always_comb begin
        state_nx       = state;
        to_nx          = to_cnt;
        to_inc         = to_cnt + TO_W'(1);
        flight_nx      = flight_color;
        req_nx         = req_color;
        req_go         = 1'b0;
        req_c          = 1'b0;
        blue_ball_nx   = 1'b0;
        red_ball_nx    = 1'b0;
        halt_reason_nx = halt_reason;
        blue_left_nx   = blue_left;
        red_left_nx    = red_left;
        blue_tray_nx   = blue_tray;
        red_tray_nx    = red_tray;
        case (state)
            S_IDLE, S_HALT: begin
                if (reload) begin
                    blue_left_nx   = CNT_W'(BLUE_COUNT);
                    red_left_nx    = CNT_W'(RED_COUNT);
                    blue_tray_nx   = '0;
                    red_tray_nx    = '0;
                    halt_reason_nx = HR_NONE;
                    state_nx       = S_IDLE;
                end else if (start && state == S_IDLE) begin
                    req_go = 1'b1;
                    req_c  = (START_COLOR != 0);
                end else begin
                    req_go = 1'b0;
                end
            end
            S_RELEASE: begin
                if (req_color) begin
                    red_ball_nx = 1'b1;
                    red_left_nx = red_left - CNT_W'(1);
                end else begin
                    blue_ball_nx = 1'b1;
                    blue_left_nx = blue_left - CNT_W'(1);
                end
                flight_nx = req_color;
                to_nx     = '0;
                state_nx  = S_FLIGHT;
            end
            S_FLIGHT: begin
                // Interceptor outranks both levers; red lever outranks blue.
                if (int_full) begin
                    state_nx       = S_HALT;
                    halt_reason_nx = HR_INT;
                end else if (red_sink || blue_sink) begin
                    if (flight_color) begin
                        red_tray_nx = sat_inc(red_tray);
                    end else begin
                        blue_tray_nx = sat_inc(blue_tray);
                    end
                    req_go = 1'b1;
                    req_c  = red_sink;
                end else if (to_inc == TO_W'(TIMEOUT)) begin
                    to_nx          = to_inc;
                    state_nx       = S_HALT;
                    halt_reason_nx = HR_TIMEOUT;
                end else begin
                    to_nx = to_inc;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        req_ok = req_c ? (red_left != '0) : (blue_left != '0);
        if (req_go && req_ok) begin
            state_nx = S_RELEASE;
            req_nx   = req_c;
        end else if (req_go) begin
            state_nx       = S_HALT;
            halt_reason_nx = HR_EMPTY;
        end else begin
            req_nx = req_color;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            to_cnt       <= '0;
            flight_color <= 1'b0;
            req_color    <= 1'b0;
            blue_ball    <= 1'b0;
            red_ball     <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            halt_reason  <= HR_NONE;
            blue_left    <= CNT_W'(BLUE_COUNT);
            red_left     <= CNT_W'(RED_COUNT);
            blue_tray    <= '0;
            red_tray     <= '0;
        end else begin
            state        <= state_nx;
            to_cnt       <= to_nx;
            flight_color <= flight_nx;
            req_color    <= req_nx;
            blue_ball    <= blue_ball_nx;
            red_ball     <= red_ball_nx;
            busy         <= (state_nx == S_RELEASE) || (state_nx == S_FLIGHT);
            halted       <= (state_nx == S_HALT);
            halt_reason  <= halt_reason_nx;
            blue_left    <= blue_left_nx;
            red_left     <= red_left_nx;
            blue_tray    <= blue_tray_nx;
            red_tray     <= red_tray_nx;
        end
    end

endmodule

// File: tb/tb_ball_launcher.sv
// Self-checking bench for ball_launcher: directed scenarios plus a randomized
// run against a ball-counting reference model.
module tb_ball_launcher;

    logic       clk = 1'b0;
    logic       rst, start, reload, blue_sink, red_sink, int_full;
    logic       blue_ball, red_ball, busy, halted;
    logic [1:0] halt_reason;
    logic [3:0] blue_left, red_left, blue_tray, red_tray;

    int checks = 0;
    int errors = 0;

    // reference model: balls per magazine/tray, colour of the ball in flight
    int m_left[2];
    int m_tray[2];
    int m_flight;

    ball_launcher dut (
        .clk(clk), .rst(rst), .start(start), .reload(reload),
        .blue_sink(blue_sink), .red_sink(red_sink), .int_full(int_full),
        .blue_ball(blue_ball), .red_ball(red_ball), .busy(busy), .halted(halted),
        .halt_reason(halt_reason), .blue_left(blue_left), .red_left(red_left),
        .blue_tray(blue_tray), .red_tray(red_tray)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_left[0] = 8; m_left[1] = 8; m_tray[0] = 0; m_tray[1] = 0; m_flight = 0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({blue_ball, red_ball, busy, halted, halt_reason} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b want 000000", {blue_ball, red_ball, busy, halted, halt_reason});
        end
        checks++;
        if ({blue_left, red_left, blue_tray, red_tray} !== {4'd8, 4'd8, 4'd0, 4'd0}) begin
            errors++; $display("FAIL reset_counts got %h want 8800", {blue_left, red_left, blue_tray, red_tray});
        end
    endtask

    task automatic test_first_release;
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if (blue_ball !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL start_latency got ball=%b busy=%b want 0 1", blue_ball, busy);
        end
        step();
        checks++;
        if ({blue_ball, red_ball} !== 2'b10 || blue_left !== 4'd7 || busy !== 1'b1) begin
            errors++; $display("FAIL first_pulse got b=%b r=%b left=%0d busy=%b want 1 0 7 1", blue_ball, red_ball, blue_left, busy);
        end
        step();
        checks++;
        if (blue_ball !== 1'b0) begin
            errors++; $display("FAIL pulse_width got %b want 0", blue_ball);
        end
    endtask

    task automatic test_sink_release;
        red_sink = 1'b1; step(); red_sink = 1'b0;
        checks++;
        if (blue_tray !== 4'd1 || red_ball !== 1'b0) begin
            errors++; $display("FAIL sink_tray got tray=%0d r=%b want 1 0", blue_tray, red_ball);
        end
        step();
        checks++;
        if ({blue_ball, red_ball} !== 2'b01 || red_left !== 4'd7) begin
            errors++; $display("FAIL red_pulse got b=%b r=%b left=%0d want 0 1 7", blue_ball, red_ball, red_left);
        end
    endtask

    task automatic test_int_priority;
        int_full = 1'b1; red_sink = 1'b1; step(); int_full = 1'b0; red_sink = 1'b0;
        checks++;
        if (halted !== 1'b1 || halt_reason !== 2'b01 || busy !== 1'b0 || blue_tray !== 4'd1 || red_tray !== 4'd0) begin
            errors++; $display("FAIL int_halt got h=%b hr=%b busy=%b trays=%0d/%0d want 1 01 0 1/0", halted, halt_reason, busy, blue_tray, red_tray);
        end
        step();
        checks++;
        if ({blue_ball, red_ball} !== 2'b00 || red_left !== 4'd7) begin
            errors++; $display("FAIL int_nopulse got %b left=%0d want 00 7", {blue_ball, red_ball}, red_left);
        end
        start = 1'b1; step(); start = 1'b0; step();
        checks++;
        if (halted !== 1'b1 || {blue_ball, red_ball} !== 2'b00) begin
            errors++; $display("FAIL halt_start_ignored got h=%b balls=%b want 1 00", halted, {blue_ball, red_ball});
        end
        reload = 1'b1; step(); reload = 1'b0;
        checks++;
        if ({halted, busy, halt_reason} !== 4'b0 || {blue_left, red_left, blue_tray, red_tray} !== {4'd8, 4'd8, 4'd0, 4'd0}) begin
            errors++; $display("FAIL halt_reload got %b %h want 0000 8800", {halted, busy, halt_reason}, {blue_left, red_left, blue_tray, red_tray});
        end
    endtask

    task automatic test_magazine_empty;
        int pulses = 0;
        start = 1'b1; reload = 1'b1; step(); start = 1'b0; reload = 1'b0; step();
        checks++;
        if (busy !== 1'b0 || blue_ball !== 1'b0) begin
            errors++; $display("FAIL reload_beats_start got busy=%b b=%b want 0 0", busy, blue_ball);
        end
        start = 1'b1; step(); start = 1'b0; step();
        pulses += int'(blue_ball);
        for (int i = 0; i < 8; i++) begin
            blue_sink = 1'b1; step(); blue_sink = 1'b0;
            if (i < 7) begin
                step();
                pulses += int'(blue_ball);
            end
        end
        checks++;
        if (pulses !== 8 || halted !== 1'b1 || halt_reason !== 2'b10 || blue_tray !== 4'd8 || blue_left !== 4'd0) begin
            errors++; $display("FAIL empty_halt got pulses=%0d h=%b hr=%b tray=%0d left=%0d want 8 1 10 8 0", pulses, halted, halt_reason, blue_tray, blue_left);
        end
        step();
        checks++;
        if ({blue_ball, red_ball} !== 2'b00) begin
            errors++; $display("FAIL empty_nopulse got %b want 00", {blue_ball, red_ball});
        end
    endtask

    task automatic test_timeout_reload;
        reload = 1'b1; step(); reload = 1'b0;
        start = 1'b1; step(); start = 1'b0; step();
        for (int i = 0; i < 254; i++) step();
        checks++;
        if (halted !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early got h=%b busy=%b want 0 1", halted, busy);
        end
        step();
        checks++;
        if (halted !== 1'b1 || halt_reason !== 2'b11 || blue_tray !== 4'd0 || red_tray !== 4'd0) begin
            errors++; $display("FAIL timeout_halt got h=%b hr=%b trays=%0d/%0d want 1 11 0/0", halted, halt_reason, blue_tray, red_tray);
        end
        reload = 1'b1; step(); reload = 1'b0;
        checks++;
        if ({halted, halt_reason} !== 3'b0 || {blue_left, red_left, blue_tray, red_tray} !== {4'd8, 4'd8, 4'd0, 4'd0}) begin
            errors++; $display("FAIL timeout_reload got %b %h want 000 8800", {halted, halt_reason}, {blue_left, red_left, blue_tray, red_tray});
        end
    endtask

    task automatic test_rst_flight;
        start = 1'b1; step(); start = 1'b0; step(); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if ({blue_ball, red_ball, busy, halted, halt_reason} !== 6'b0 || {blue_left, red_left, blue_tray, red_tray} !== {4'd8, 4'd8, 4'd0, 4'd0}) begin
            errors++; $display("FAIL rst_flight got %b %h want 000000 8800", {blue_ball, red_ball, busy, halted, halt_reason}, {blue_left, red_left, blue_tray, red_tray});
        end
        start = 1'b1; step(); start = 1'b0; step();
        checks++;
        if ({blue_ball, red_ball} !== 2'b10 || blue_left !== 4'd7) begin
            errors++; $display("FAIL rst_restart got %b left=%0d want 10 7", {blue_ball, red_ball}, blue_left);
        end
    endtask

    task automatic test_random;
        logic [2:0] ev;
        int  exp_hr;
        int  c;
        do_reset();
        for (int run = 0; run < 4; run++) begin
            start = 1'b1; step(); start = 1'b0; step();
            m_left[0]--; m_flight = 0;
            checks++;
            if ({blue_ball, red_ball} !== 2'b10) begin
                errors++; $display("FAIL rnd_start run=%0d got %b want 10", run, {blue_ball, red_ball});
            end
            for (int n = 0; n < 20; n++) begin
                repeat ($urandom_range(0, 3)) step();
                ev = 3'($urandom_range(1, 7));
                if ($urandom_range(0, 3) != 0) ev[2] = 1'b0;
                if (ev == 3'b000) ev = 3'b001;
                int_full = ev[2]; red_sink = ev[1]; blue_sink = ev[0];
                step();
                int_full = 1'b0; red_sink = 1'b0; blue_sink = 1'b0;
                exp_hr = 0;
                c = int'(ev[1]);
                if (ev[2]) begin
                    exp_hr = 1;
                end else begin
                    if (m_tray[m_flight] < 15) m_tray[m_flight]++;
                    if (m_left[c] == 0) exp_hr = 2;
                end
                checks++;
                if (halted !== (exp_hr != 0) || halt_reason !== 2'(exp_hr) || blue_tray !== 4'(m_tray[0]) || red_tray !== 4'(m_tray[1])) begin
                    errors++; $display("FAIL rnd_event ev=%b got h=%b hr=%0d trays=%0d/%0d want hr=%0d trays=%0d/%0d", ev, halted, halt_reason, blue_tray, red_tray, exp_hr, m_tray[0], m_tray[1]);
                end
                if (exp_hr != 0) break;
                step();
                m_left[c]--; m_flight = c;
                checks++;
                if (blue_ball !== (c == 0) || red_ball !== (c == 1) || blue_left !== 4'(m_left[0]) || red_left !== 4'(m_left[1])) begin
                    errors++; $display("FAIL rnd_pulse got b=%b r=%b left=%0d/%0d want colour=%0d left=%0d/%0d", blue_ball, red_ball, blue_left, red_left, c, m_left[0], m_left[1]);
                end
            end
            reload = 1'b1; step(); reload = 1'b0;
            m_left[0] = 8; m_left[1] = 8; m_tray[0] = 0; m_tray[1] = 0;
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; reload = 1'b0;
        blue_sink = 1'b0; red_sink = 1'b0; int_full = 1'b0;
        test_reset();
        test_first_release();
        test_sink_release();
        test_int_priority();
        test_magazine_empty();
        test_timeout_reload();
        test_rst_flight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
